// File: rtl/bennett_operand_sequencer_pkg.sv
// bennett_seq_pkg: shared types and defaults for the Bennett operand sequencer.
package bennett_seq_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int TIMEOUT_DEF = 1024;

  // state | meaning
  // IDLE  | ready for a request, operands from the last transaction still driven
  // WAIT  | operands held, counting instFlag edges and timeout cycles
  // RESP  | result presented on out_*, waiting for the consumer handshake
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_t;

  // Result record at the default width; the top builds a WIDTH-sized twin.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] sum;
    logic                 cout;
    logic                 timeout;
    logic                 mismatch;
  } seq_result_t;

endpackage

// File: rtl/bennett_operand_sequencer_inst_flag_edge.sv
// inst_flag_edge: rising-edge detector for the Bennett instFlag.
// The history register resets to 1 so a flag already high when reset is
// released does not look like a fresh completion.
module inst_flag_edge (
  input  logic clk,
  input  logic reset,
  input  logic inst_flag,
  output logic rise
);

  logic flag_q;

  // track the previous flag level
  always_ff @(posedge clk) begin
    if (reset) flag_q <= 1'b1;
    else       flag_q <= inst_flag;
  end

  assign rise = inst_flag & ~flag_q;

endmodule

// File: rtl/bennett_operand_sequencer.sv
// bennett_operand_sequencer: holds adder operands across a Bennett evaluation,
// captures the datapath result on an instFlag rising edge and returns it over
// a valid/ready interface, or reports a timeout.
// Optional build macro BENNETT_SEQ_GOLDEN_CHECK_EN adds a golden a+b+cin
// compare that drives out_mismatch; without it out_mismatch is tied low.
module bennett_operand_sequencer
  import bennett_seq_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int SETTLE_EDGES   = 0,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             inst_flag,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_timeout,
  output logic             out_mismatch,
  output logic             busy
);

  localparam int EW = (SETTLE_EDGES < 1) ? 1 : $clog2(SETTLE_EDGES + 1);
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             timeout;
    logic             mismatch;
  } result_t;

  seq_state_t       state, state_nxt;
  logic             flag_rise;
  logic             launch, capture, count_edge, time_out;
  logic             mismatch_w;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q;
  logic [EW-1:0]    edge_cnt;
  logic [TW-1:0]    to_cnt;
  result_t          result_q;

  inst_flag_edge u_edge (
    .clk       (clk),
    .reset     (reset),
    .inst_flag (inst_flag),
    .rise      (flag_rise)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state and per-cycle control strobes
  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    capture    = 1'b0;
    count_edge = 1'b0;
    time_out   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          launch    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // a capture edge takes priority over a timeout in the same cycle
        if (flag_rise && (int'(edge_cnt) >= SETTLE_EDGES)) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          count_edge = flag_rise;
          if (int'(to_cnt) == TIMEOUT_CYCLES - 1) begin
            time_out  = 1'b1;
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BENNETT_SEQ_GOLDEN_CHECK_EN
  logic [WIDTH:0] golden_q;

  // golden sum taken from the request at launch
  always_ff @(posedge clk) begin
    if (reset)       golden_q <= '0;
    else if (launch) golden_q <= {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, in_cin};
  end

  assign mismatch_w = ({dut_cout, dut_sum} != golden_q);
`else
  assign mismatch_w = 1'b0;
`endif

  // operand hold, edge/timeout counters and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      edge_cnt <= '0;
      to_cnt   <= '0;
      result_q <= '0;
    end else begin
      if (launch) begin
        a_q      <= in_a;
        b_q      <= in_b;
        cin_q    <= in_cin;
        edge_cnt <= '0;
        to_cnt   <= '0;
      end
      if (state == WAIT) to_cnt <= to_cnt + TW'(1);
      if (count_edge)    edge_cnt <= edge_cnt + EW'(1);
      if (capture) begin
        result_q <= '{sum: dut_sum, cout: dut_cout, timeout: 1'b0, mismatch: mismatch_w};
      end else if (time_out) begin
        result_q <= '{sum: '0, cout: 1'b0, timeout: 1'b1, mismatch: 1'b0};
      end
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == RESP);
  assign busy         = (state != IDLE);
  assign dut_a        = a_q;
  assign dut_b        = b_q;
  assign dut_cin      = cin_q;
  assign out_sum      = result_q.sum;
  assign out_cout     = result_q.cout;
  assign out_timeout  = result_q.timeout;
  assign out_mismatch = result_q.mismatch;

endmodule

// File: tb/tb_bennett_operand_sequencer.sv
// Bench for bennett_operand_sequencer: two instances (no settle edges with a
// short timeout, one settle edge) each wrapped around a behavioural adder.
module tb_bennett_operand_sequencer;

`ifdef BENNETT_SEQ_GOLDEN_CHECK_EN
  localparam logic EXP_MIS = 1'b1;
`else
  localparam logic EXP_MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_flag = 1'b0;
  logic        out_ready = 1'b1;
  logic        corrupt = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        inv  [2];
  logic        rdy  [2];
  logic        ov   [2];
  logic        bsy  [2];
  logic        otmo [2];
  logic        omis [2];
  logic        ocout[2];
  logic        dcin [2];
  logic        scout[2];
  logic [15:0] osum [2];
  logic [15:0] da   [2];
  logic [15:0] db   [2];
  logic [15:0] ssum [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // behavioural adder datapath; corrupt forces dut_sum of instance 0 to zero
  assign {scout[0], ssum[0]} = corrupt ? {scout[0], 16'h0000} & 17'h0 | {({1'b0, da[0]} + {1'b0, db[0]} + {16'h0, dcin[0]})} & 17'h10000
                                       : {1'b0, da[0]} + {1'b0, db[0]} + {16'h0, dcin[0]};
  assign {scout[1], ssum[1]} = {1'b0, da[1]} + {1'b0, db[1]} + {16'h0, dcin[1]};

  bennett_operand_sequencer #(.WIDTH(16), .SETTLE_EDGES(0), .TIMEOUT_CYCLES(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid(inv[0]), .in_ready(rdy[0]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .inst_flag(inst_flag),
    .dut_a(da[0]), .dut_b(db[0]), .dut_cin(dcin[0]),
    .dut_sum(ssum[0]), .dut_cout(scout[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_sum(osum[0]), .out_cout(ocout[0]),
    .out_timeout(otmo[0]), .out_mismatch(omis[0]), .busy(bsy[0])
  );

  bennett_operand_sequencer #(.WIDTH(16), .SETTLE_EDGES(1), .TIMEOUT_CYCLES(64)) dut1 (
    .clk(clk), .reset(reset), .in_valid(inv[1]), .in_ready(rdy[1]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .inst_flag(inst_flag),
    .dut_a(da[1]), .dut_b(db[1]), .dut_cin(dcin[1]),
    .dut_sum(ssum[1]), .dut_cout(scout[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_sum(osum[1]), .out_cout(ocout[1]),
    .out_timeout(otmo[1]), .out_mismatch(omis[1]), .busy(bsy[1])
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // present a request for one cycle; returns on the negedge after launch
  task automatic launch(input int s, input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    in_a = a; in_b = b; in_cin = c; inv[s] = 1'b1;
    @(negedge clk);
    inv[s] = 1'b0;
    chk1("in_ready_drop", rdy[s], 1'b0);
    chk1("busy_high", bsy[s], 1'b1);
    chk16("dut_a_held", da[s], a);
  endtask

  task automatic pulse();
    inst_flag = 1'b1;
    @(negedge clk);
    inst_flag = 1'b0;
  endtask

  task automatic wait_valid(input int s, output int cyc);
    cyc = 0;
    while (!ov[s] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // out_ready assumed high: one edge completes the handshake
  task automatic handshake(input int s);
    @(negedge clk);
    chk1("idle_after_hs_valid", ov[s], 1'b0);
    chk1("idle_after_hs_ready", rdy[s], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    inv[0] = 1'b0;
    inv[1] = 1'b0;
    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[4] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0};
    vecs[5] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
    vecs[6] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    chk1("rst_in_ready", rdy[0], 1'b1);
    chk1("rst_out_valid", ov[0], 1'b0);
    chk1("rst_busy", bsy[0], 1'b0);
    chk16("rst_dut_a", da[0], 16'h0000);
    chk16("rst_out_sum", osum[0], 16'h0000);
    chk1("rst_timeout", otmo[0], 1'b0);
    reset = 1'b0;

    // table: capture one cycle after the first edge past launch
    for (int i = 0; i < 8; i++) begin
      launch(0, vecs[i].a, vecs[i].b, vecs[i].cin);
      pulse();
      chk1("vec_valid_latency", ov[0], 1'b1);
      chk16("vec_sum", osum[0], vecs[i].exp_sum);
      chk1("vec_cout", ocout[0], vecs[i].exp_cout);
      chk1("vec_timeout", otmo[0], 1'b0);
      chk1("vec_mismatch", omis[0], 1'b0);
      handshake(0);
    end

    // backpressure: result must stay put while out_ready is low
    out_ready = 1'b0;
    launch(0, 16'h000F, 16'h0001, 1'b0);
    pulse();
    for (int k = 0; k < 5; k++) begin
      chk1("stall_valid", ov[0], 1'b1);
      chk16("stall_sum", osum[0], 16'h0010);
      chk1("stall_cout", ocout[0], 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    handshake(0);

    // one settle edge: first edge ignored, second captures
    launch(1, 16'h0011, 16'hFF11, 1'b1);
    pulse();
    chk1("settle_first_edge_ignored", ov[1], 1'b0);
    @(negedge clk);
    pulse();
    chk1("settle_second_edge_valid", ov[1], 1'b1);
    chk16("settle_sum", osum[1], 16'hFF23);
    chk1("settle_cout", ocout[1], 1'b0);
    handshake(1);
    launch(1, 16'hFFFF, 16'hFFFF, 1'b0);
    pulse();
    chk1("settle2_first_edge_ignored", ov[1], 1'b0);
    @(negedge clk);
    pulse();
    chk1("settle2_valid", ov[1], 1'b1);
    chk16("settle2_sum", osum[1], 16'hFFFE);
    chk1("settle2_cout", ocout[1], 1'b1);
    handshake(1);

    // inst_flag high across reset release: only a real 0->1 edge captures
    @(negedge clk);
    inst_flag = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    launch(0, 16'h1234, 16'h5678, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk1("flag_high_no_capture", ov[0], 1'b0);
      @(negedge clk);
    end
    inst_flag = 1'b0;
    @(negedge clk);
    pulse();
    chk1("flag_edge_valid", ov[0], 1'b1);
    chk16("flag_edge_sum", osum[0], 16'h68AD);
    chk1("flag_edge_cout", ocout[0], 1'b0);
    handshake(0);

    // timeout with inst_flag idle low
    launch(0, 16'h0101, 16'h0202, 1'b0);
    wait_valid(0, cyc);
    chkn("timeout_latency", cyc, 16);
    chk1("timeout_flag", otmo[0], 1'b1);
    chk16("timeout_sum", osum[0], 16'h0000);
    chk1("timeout_cout", ocout[0], 1'b0);
    chk1("timeout_mismatch", omis[0], 1'b0);
    handshake(0);

    // reset during WAIT
    launch(0, 16'h4444, 16'h1111, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk1("midrst_in_ready", rdy[0], 1'b1);
    chk1("midrst_busy", bsy[0], 1'b0);
    chk1("midrst_valid", ov[0], 1'b0);
    chk16("midrst_dut_a", da[0], 16'h0000);
    reset = 1'b0;

    // corrupted datapath sum
    corrupt = 1'b1;
    launch(0, 16'h0001, 16'h0001, 1'b0);
    pulse();
    chk1("golden_valid", ov[0], 1'b1);
    chk16("golden_sum_forced", osum[0], 16'h0000);
    chk1("golden_mismatch", omis[0], EXP_MIS);
    handshake(0);
    corrupt = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bennett_operand_sequencer.md
Name: bennett_operand_sequencer

Overview:
- Drives operands into an adiabatic datapath (the 16-bit adiabatic adder) that is clocked by the Bennett phase generator.
- Holds the operands stable across a full Bennett evaluation cycle, then captures the datapath result on the rising edge of instFlag.
- Returns the result over a valid/ready interface.
- Consumer end of the instFlag completion interface; replaces hand-timed testbench stimulus in system-level and ALU integration.

Parameters:
- WIDTH, 16: operand and sum width.
- SETTLE_EDGES, 0: instFlag rising edges ignored after launch, before the capturing edge.
- TIMEOUT_CYCLES, 1024: clk cycles allowed between launch and capture before a timeout is reported.

Ports:
- clk  input  1  system clock (same clk that feeds bennett_clock).
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  sequencer can accept a request.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- inst_flag  input  1  instFlag from bennett_clock.
- dut_a  output  WIDTH  held operand A to the datapath.
- dut_b  output  WIDTH  held operand B to the datapath.
- dut_cin  output  1  held carry-in to the datapath.
- dut_sum  input  WIDTH  datapath sum.
- dut_cout  input  1  datapath carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumer ready.
- out_sum  output  WIDTH  captured sum.
- out_cout  output  1  captured carry-out.
- out_timeout  output  1  result is a timeout, not a capture.
- out_mismatch  output  1  golden-check failure (see Optional Feature).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0 except in_ready=1; dut_* = 0; counters = 0; flag_q = 1.
  - flag_q resets to 1 so that an inst_flag already high at reset release does not create a false edge.
- Edge detection: edge = inst_flag & ~flag_q, with flag_q registered every cycle. inst_flag may stay high for many cycles; only the 0->1 transition counts.
- IDLE: in_ready=1. When in_valid is high, latch in_a/in_b/in_cin into dut_a/dut_b/dut_cin on that clock edge, clear the edge and timeout counters, and go to WAIT.
  - in_ready drops the next cycle.
  - An edge in the launch cycle itself is not counted.
- WAIT: in_ready=0; dut_* held constant.
  - On each edge, if edge_cnt < SETTLE_EDGES, increment edge_cnt and stay.
  - Otherwise register dut_sum/dut_cout into out_sum/out_cout, set out_timeout=0, and go to RESP.
  - The timeout counter increments every cycle. When it reaches TIMEOUT_CYCLES-1 with no capture, set out_timeout=1, set out_sum=0 and out_cout=0, and go to RESP.
  - If a capture edge and timeout occur in the same cycle, the capture wins.
- RESP: out_valid=1; out_* stable until out_valid & out_ready. On the handshake, go to IDLE with out_valid=0 the next cycle.
  - dut_* keep their last values; they are not cleared.
  - Edges arriving in RESP are ignored.
- Latency: capture occurs 1 cycle after the (SETTLE_EDGES+1)-th edge strictly after launch. out_valid rises that same cycle.
- Throughput: at most one transaction in flight. in_valid while busy is not accepted; the requester must hold it.
- Reset mid-operation: returns to the reset state immediately; any in-flight result is discarded.

Optional Feature:
- Macro: BENNETT_SEQ_GOLDEN_CHECK_EN.
- Defined:
  - At launch, compute the golden value {cout,sum} = a + b + cin at WIDTH+1 bits, modulo 2^(WIDTH+1).
  - At capture, set out_mismatch=1 if {dut_cout,dut_sum} differs from the golden value. out_mismatch is valid with out_valid.
  - out_mismatch=0 for a timeout result.
- Undefined: out_mismatch is tied to 0 and no golden register is built.

Decomposition:
- Package bennett_seq_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - default localparams WIDTH_DEF=16 and TIMEOUT_DEF=1024;
  - the result struct {sum, cout, timeout, mismatch}.
- Sub-module inst_flag_edge is natural: flag_q register plus the rising-edge pulse, reset value 1.

Test Plan:
- Reset, then launch a=0000 b=0000 cin=0 -> in_ready drops; out_valid after the 1st instFlag edge; out_sum=0000, out_cout=0.
- Launch a=000F b=0001 cin=0, with out_ready held low for 5 cycles -> out_sum=0010, cout=0, outputs stable for all 5 cycles, IDLE the cycle after the handshake.
- a=0011 b=FF11 cin=1 with SETTLE_EDGES=1 -> the first edge is ignored; capture on the 2nd edge; out_sum=FF23, cout=0. Then a=FFFF b=FFFF cin=0 -> out_sum=FFFE, cout=1.
- inst_flag held high across reset release, then a=1234 b=5678 cin=1 launched -> no capture until a true 0->1 edge; out_sum=68AD, cout=0.
- inst_flag tied 0, TIMEOUT_CYCLES=16 -> out_valid 16 cycles after launch; out_timeout=1, out_sum=0. Assert reset during WAIT in a rerun -> IDLE with in_ready=1 on the next cycle.
- With BENNETT_SEQ_GOLDEN_CHECK_EN, force dut_sum=0000 for a=0001 b=0001 -> out_mismatch=1; without the macro -> out_mismatch=0.
